// File: rtl/pipo_rr_scheduler.sv
// Round-robin owner of a shared PIPO register: holds load high for a fixed window per grant.
// Define PIPO_SCHED_EARLY_RELEASE_EN to end a grant as soon as the grantee drops req.
module pipo_rr_scheduler #(
   parameter int WIDTH       = 4,
   parameter int NREQ        = 4,
   parameter int HOLD_CYCLES = 3,
   localparam int OWNER_W    = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         gnt,
   output logic [OWNER_W-1:0]      owner,
   output logic                    busy,
   output logic                    reg_load,
   output logic [WIDTH-1:0]        reg_in,
   output logic                    done
);

   localparam int CNT_W = 4;

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OWNER_W-1:0] last_q, last_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [WIDTH-1:0]   reg_in_q, reg_in_d;

   logic               hi_found, lo_found;
   logic [OWNER_W-1:0] hi_idx, lo_idx, win_idx;
   logic [WIDTH-1:0]   win_data;
   logic               done_w;

   // Lowest requester above the pointer wins, else lowest overall (wrap).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[OWNER_W'(i)] && (OWNER_W'(i) > last_q)) begin
            hi_found = 1'b1;
            hi_idx   = OWNER_W'(i);
         end
         if (req[OWNER_W'(i)]) begin
            lo_found = 1'b1;
            lo_idx   = OWNER_W'(i);
         end
      end
      win_idx  = hi_found ? hi_idx : lo_idx;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == OWNER_W'(i)) begin
            win_data = data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      done_w = 1'b0;
      if (state_q == S_HOLD) begin
`ifdef PIPO_SCHED_EARLY_RELEASE_EN
         done_w = (cnt_q == '0) || !req[owner_q];
`else
         done_w = (cnt_q == '0);
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      owner_d  = owner_q;
      gnt_d    = gnt_q;
      reg_in_d = reg_in_q;
      unique case (state_q)
         S_IDLE: begin
            if (lo_found) begin
               state_d         = S_HOLD;
               cnt_d           = CNT_W'(HOLD_CYCLES - 1);
               last_d          = win_idx;
               owner_d         = win_idx;
               gnt_d           = '0;
               gnt_d[win_idx]  = 1'b1;
               reg_in_d        = win_data;
            end
         end
         S_HOLD: begin
            if (done_w) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               owner_d  = '0;
               gnt_d    = '0;
               reg_in_d = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         last_q   <= OWNER_W'(NREQ - 1);
         owner_q  <= '0;
         gnt_q    <= '0;
         reg_in_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         reg_in_q <= reg_in_d;
      end
   end

   assign gnt      = gnt_q;
   assign owner    = owner_q;
   assign busy     = (state_q == S_HOLD);
   assign reg_load = (state_q == S_HOLD);
   assign reg_in   = reg_in_q;
   assign done     = done_w;

endmodule

// File: tb/tb_pipo_rr_scheduler.sv
// Bench for pipo_rr_scheduler: directed scenarios then random traffic,
// compared against a grant-level reference model.
module tb_pipo_rr_scheduler;

   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int HOLD  = 3;
   localparam int OW    = $clog2(NREQ);
`ifdef PIPO_SCHED_EARLY_RELEASE_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic [OW-1:0]         owner;
   logic                  busy;
   logic                  reg_load;
   logic [WIDTH-1:0]      reg_in;
   logic                  done;

   int checks = 0;
   int errors = 0;

   pipo_rr_scheduler #(
      .WIDTH(WIDTH), .NREQ(NREQ), .HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .data(data),
      .gnt(gnt), .owner(owner), .busy(busy),
      .reg_load(reg_load), .reg_in(reg_in), .done(done)
   );

   always #5 clk = ~clk;

   // Reference: current grantee (-1 idle), load cycles left, pointer, captured data.
   int               m_owner = -1;
   int               m_left  = 0;
   int               m_last  = NREQ - 1;
   logic [WIDTH-1:0] m_reg   = '0;

   function automatic bit m_done();
      if (m_owner < 0) return 1'b0;
      return (m_left == 1) || (EARLY && !req[m_owner]);
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_owner = -1;
         m_left  = 0;
         m_last  = NREQ - 1;
         m_reg   = '0;
      end else if (m_owner >= 0) begin
         if (m_done()) begin
            m_owner = -1;
            m_reg   = '0;
         end else begin
            m_left = m_left - 1;
         end
      end else if (req != '0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
         m_left = HOLD;
         m_last = m_owner;
         m_reg  = data[m_owner*WIDTH +: WIDTH];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs();
      logic [NREQ-1:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("owner", 32'(owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("reg_load", 32'(reg_load), 32'(m_owner >= 0));
      chk("reg_in", 32'(reg_in), 32'(m_reg));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic tick();
      #1;
      chk("done", 32'(done), 32'(m_done()));
      model_edge();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      data[i*WIDTH +: WIDTH] = v;
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      data = '0;
      @(posedge clk);
      #1;

      // Reset held with all requests high.
      req  = 4'b1111;
      data = {NREQ*WIDTH{1'b1}};
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      tick();
      chk("rst_reg_in", 32'(reg_in), 32'd0);
      rst = 1'b0;
      tick();
      chk("first_winner", 32'(gnt), 32'b0001);

      // Round robin with continuous requests and distinct data.
      set_data(0, 4'h1); set_data(1, 4'h2);
      set_data(2, 4'h3); set_data(3, 4'h4);
      for (int n = 0; n < 18; n++) begin
         tick();
         if (n == 2) chk("rr_gap", 32'(reg_load), 32'd0);
         if (n == 3) chk("rr_second", 32'(owner), 32'd1);
      end

      // Single requester, regrant after one idle cycle.
      do_reset();
      req = 4'b0100;
      set_data(2, 4'hA);
      tick();
      chk("single_in", 32'(reg_in), 32'hA);
      for (int n = 0; n < 9; n++) tick();

      // Data freeze: slice changes mid-grant.
      do_reset();
      req = 4'b0010;
      set_data(1, 4'h5);
      tick();
      tick();
      set_data(1, 4'hF);
      tick();
      chk("freeze", 32'(reg_in), 32'h5);
      tick();
      tick();

      // Reset mid-grant: pointer must return to NREQ-1.
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b1111;
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_load", 32'(reg_load), 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_winner", 32'(owner), 32'd0);
      for (int n = 0; n < 4; n++) tick();

      // Grantee drops its request in the first hold cycle.
      do_reset();
      req = 4'b1000;
      set_data(3, 4'hC);
      tick();
      req = 4'b0000;
      #1;
      chk("early_done", 32'(done), EARLY ? 32'd1 : 32'd0);
      tick();
      chk("early_load", 32'(reg_load), EARLY ? 32'd0 : 32'd1);
      for (int n = 0; n < 4; n++) tick();

      // Random traffic with occasional reset.
      for (int n = 0; n < 400; n++) begin
         rst  = ($urandom_range(0, 39) == 0);
         req  = NREQ'($urandom);
         data = (NREQ*WIDTH)'($urandom);
         tick();
      end
      rst = 1'b0;
      req = '0;
      for (int n = 0; n < HOLD + 2; n++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
